rr_arbiter_32: RTL and testbench

//  Round-robin arbiter sharing one resource among 32 requesters. Emits the one-hot

---
 rtl/arb_pkg.sv | 11 +
 rtl/onehot_to_bin32.sv | 21 ++
 rtl/rr_arbiter_32.sv | 128 ++++++++++++
 tb/tb_rr_arbiter_32.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 32-way round-robin arbiter.
package arb_pkg;
  localparam int N            = 32;
  localparam int IDX_W        = 5;
  localparam int MAX_HOLD_DEF = 255;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;
endpackage

// File: rtl/onehot_to_bin32.sv
// Combinational 32-bit one-hot to 5-bit index encoder; zero or multi-hot input yields 0.
module onehot_to_bin32
  import arb_pkg::*;
(
  input  logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx
);

  logic             is_onehot;
  logic [IDX_W-1:0] enc;

  always_comb begin
    is_onehot = (onehot != '0) && ((onehot & (onehot - N'(1))) == '0);
    enc       = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) enc = enc | IDX_W'(i);
    end
    idx = is_onehot ? enc : '0;
  end

endmodule

// File: rtl/rr_arbiter_32.sv
// Round-robin arbiter for 32 requesters with held grants and rotating priority.
// Optional forced release after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter_32
  import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
  #(parameter int unsigned MAX_HOLD = MAX_HOLD_DEF)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q, timeout_d;

  logic [IDX_W-1:0] shift;
  logic [IDX_W-1:0] src;
  logic [N-1:0]     req_rot;
  logic [N-1:0]     rot_first;
  logic [IDX_W-1:0] rot_idx;
  logic [IDX_W-1:0] win_idx;
  logic             owner_req;
  logic             hold_hit;

  // Rotate so that bit 0 of req_rot is requester ptr+1; the lowest set bit is the winner.
  always_comb begin
    shift   = ptr_q + IDX_W'(1);
    src     = '0;
    req_rot = '0;
    for (int i = 0; i < N; i++) begin
      src        = IDX_W'(i) + shift;
      req_rot[i] = req[src];
    end
    rot_first = req_rot & (~req_rot + N'(1));
  end

  onehot_to_bin32 u_enc (
    .onehot (rot_first),
    .idx    (rot_idx)
  );

  assign win_idx   = rot_idx + shift;
  assign owner_req = req[gnt_idx_q];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;

  assign hold_hit = (hold_q == 8'(MAX_HOLD - 1));

  always_comb begin
    hold_d = hold_q;
    if (state_q == IDLE) hold_d = '0;
    else                 hold_d = hold_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`else
  assign hold_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req != '0) begin
          state_d     = GRANT;
          gnt_d       = N'(1) << win_idx;
          gnt_idx_d   = win_idx;
          gnt_valid_d = 1'b1;
          ptr_d       = win_idx;
        end
      end
      GRANT: begin
        if (done || !owner_req || hold_hit) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
          // A normal release on the same edge takes precedence over the timeout flag.
          timeout_d   = hold_hit && !done && owner_req;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= IDX_W'(N - 1);
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_32.sv
// Directed scoreboard bench for rr_arbiter_32; timeout steps run when ARB_TIMEOUT_EN is defined.
module tb_rr_arbiter_32;

  logic        clk;
  logic        rst;
  logic [31:0] req;
  logic        done;
  logic [31:0] gnt;
  logic [4:0]  gnt_idx;
  logic        gnt_valid;
  logic        timeout;

  typedef struct {
    logic        valid;
    logic [4:0]  idx;
    logic        tmo;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

`ifdef ARB_TIMEOUT_EN
  rr_arbiter_32 #(.MAX_HOLD(4)) dut (
`else
  rr_arbiter_32 dut (
`endif
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic [31:0] r, input logic d, input logic rs,
                      input logic ev, input logic [4:0] ei, input logic et,
                      input string tag);
    exp_t        e;
    exp_t        got;
    logic [31:0] egnt;
    @(negedge clk);
    req  = r;
    done = d;
    rst  = rs;
    e.valid = ev;
    e.idx   = ev ? ei : 5'd0;
    e.tmo   = et;
    e.tag   = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got  = exp_q.pop_front();
    egnt = got.valid ? (32'd1 << got.idx) : 32'd0;
    vectors++;
    assert (gnt_valid === got.valid) else begin
      miscompares++;
      $error("FAIL %s gnt_valid got %0b expected %0b", got.tag, gnt_valid, got.valid);
    end
    assert (gnt === egnt) else begin
      miscompares++;
      $error("FAIL %s gnt got %08h expected %08h", got.tag, gnt, egnt);
    end
    assert (gnt_idx === got.idx) else begin
      miscompares++;
      $error("FAIL %s gnt_idx got %0d expected %0d", got.tag, gnt_idx, got.idx);
    end
    assert (timeout === got.tmo) else begin
      miscompares++;
      $error("FAIL %s timeout got %0b expected %0b", got.tag, timeout, got.tmo);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;

    // Reset dominates a full request vector, then first grant goes to bit 0.
    step(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, "rst_all_req");
    step(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, "rst_all_req2");

    // Full request with done each grant: strict order 0..31 then 0.
    for (int i = 0; i <= 32; i++) begin
      step(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 5'(i % 32), 1'b0, "fair_grant");
      if (i == 5)
        step(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, "fair_hold");
      step(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, "fair_dead");
    end

    // Two requesters alternate 2,4,2 with one dead cycle each.
    step(32'h0000_0000, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, "rst2");
    step(32'h0000_0014, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, "alt_g2");
    step(32'h0000_0014, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, "alt_hold2");
    step(32'h0000_0014, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, "alt_dead1");
    step(32'h0000_0014, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, "alt_g4");
    step(32'h0000_0014, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, "alt_dead2");
    step(32'h0000_0014, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, "alt_g2b");
    step(32'h0000_0014, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, "alt_dead3");

    // Wrap from ptr=31 to bit 0, and sole requester at ptr is re-granted.
    step(32'h0000_0000, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, "rst3");
    step(32'h8000_0000, 1'b0, 1'b0, 1'b1, 5'd31, 1'b0, "wrap_g31");
    step(32'h8000_0000, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, "wrap_dead");
    step(32'h8000_0001, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, "wrap_g0");
    step(32'h8000_0001, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, "wrap_dead2");
    step(32'h0000_0001, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, "same_regrant");
    step(32'h0000_0001, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, "same_dead");

    // Owner drops its request, idle behaviour, done ignored in IDLE, reset mid-grant.
    step(32'h0000_0020, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, "drop_g5");
    step(32'h0000_0000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, "drop_rel");
    step(32'h0000_0000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, "idle_noreq");
    step(32'h0000_0000, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, "idle_done");
    step(32'h0000_0008, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, "idle_done_req");
    step(32'h0000_0008, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, "idle_done_rel");
    step(32'h0000_0040, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0, "mid_g6");
    step(32'h0000_0040, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0, "mid_hold6");
    step(32'h0000_0040, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, "mid_rst");
    step(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, "post_rst_g0");

`ifdef ARB_TIMEOUT_EN
    // Forced release after four grant cycles, then done wins over timeout.
    step(32'h0000_0000, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, "rst_tmo");
    step(32'h0000_0008, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, "tmo_g3");
    for (int i = 0; i < 3; i++)
      step(32'h0000_0008, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, "tmo_hold");
    step(32'h0000_0008, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, "tmo_fire");
    step(32'h0000_0008, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, "tmo_regrant");
    for (int i = 0; i < 3; i++)
      step(32'h0000_0008, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, "tmo_hold2");
    step(32'h0000_0008, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, "tmo_done_wins");
    step(32'h0000_0000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, "tmo_idle");
`else
    // Without the timeout the grant is held indefinitely.
    for (int i = 0; i < 300; i++)
      step(32'h0000_0001, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, "long_hold");
    step(32'h0000_0001, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, "long_rel");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
